// File: rtl/input_buffer_window_sequencer.sv
// Sliding-window loader: pops a first-word-fall-through FIFO into the scratchpad,
// fills a full window, then refills STRIDE words per consume in circular order.
module input_buffer_window_sequencer #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned SCRATCH_DEPTH = 4,
    parameter int unsigned STRIDE        = 1,
    parameter int unsigned ADDR_W        = $clog2(SCRATCH_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  clear,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_ren,
    output logic                  scratch_wen,
    output logic [ADDR_W-1:0]     scratch_waddr,
    output logic [DATA_WIDTH-1:0] scratch_wdata,
    input  logic                  consume,
    output logic                  window_valid,
    output logic [ADDR_W-1:0]     window_base,
    output logic [ADDR_W:0]       fill_cnt,
    output logic                  busy
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;
    localparam logic [1:0] S_SLIDE = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(SCRATCH_DEPTH - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT  = CNT_W'(SCRATCH_DEPTH);
    localparam logic [CNT_W-1:0]  STRIDE_CNT = CNT_W'(STRIDE);

    logic [1:0]        state, state_nx;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_nx, base_nx;
    logic [CNT_W-1:0]  cnt_nx, cnt_inc, base_sum;
    logic              pop_c;

    // Pop is unregistered so FIFO data lands in the scratchpad with no added latency
    assign pop_c         = ((state == S_FILL) || (state == S_SLIDE)) && !fifo_empty && !clear;
    assign fifo_ren      = pop_c;
    assign scratch_wen   = pop_c;
    assign scratch_waddr = wr_ptr;
    assign scratch_wdata = pop_c ? fifo_dout : '0;

    // Next-state, pointer and counter update
    always_comb begin
        state_nx  = state;
        wr_ptr_nx = wr_ptr;
        cnt_nx    = fill_cnt;
        base_nx   = window_base;
        cnt_inc   = fill_cnt + CNT_W'(1);
        base_sum  = {1'b0, window_base} + STRIDE_CNT;

        if (pop_c) begin
            wr_ptr_nx = (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + ADDR_W'(1);
        end

        if (clear) begin
            state_nx  = S_IDLE;
            wr_ptr_nx = '0;
            cnt_nx    = '0;
            base_nx   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nx = S_FILL;
                        cnt_nx   = '0;
                    end
                end
                S_FILL: begin
                    if (pop_c) begin
                        if (cnt_inc == DEPTH_CNT) begin
                            state_nx = S_READY;
                            cnt_nx   = '0;
                        end else begin
                            cnt_nx = cnt_inc;
                        end
                    end
                end
                S_READY: begin
                    if (consume) begin
                        state_nx = S_SLIDE;
                        cnt_nx   = '0;
                        base_nx  = (base_sum >= DEPTH_CNT) ? ADDR_W'(base_sum - DEPTH_CNT)
                                                           : ADDR_W'(base_sum);
                    end
                end
                S_SLIDE: begin
                    if (pop_c) begin
                        if (cnt_inc == STRIDE_CNT) begin
                            state_nx = S_READY;
                            cnt_nx   = '0;
                        end else begin
                            cnt_nx = cnt_inc;
                        end
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Status flags decode the upcoming state so they line up with it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            wr_ptr       <= '0;
            window_base  <= '0;
            fill_cnt     <= '0;
            window_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nx;
            wr_ptr       <= wr_ptr_nx;
            window_base  <= base_nx;
            fill_cnt     <= cnt_nx;
            window_valid <= (state_nx == S_READY);
            busy         <= (state_nx == S_FILL) || (state_nx == S_SLIDE);
        end
    end

endmodule

// File: tb/tb_input_buffer_window_sequencer.sv
// Scoreboard bench: stimulus queues expected scratchpad writes, a negedge monitor checks them.
module tb_input_buffer_window_sequencer;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 2;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start, clear, consume;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic          fifo_ren, scratch_wen, window_valid, busy;
    logic [AW-1:0] scratch_waddr, window_base;
    logic [DW-1:0] scratch_wdata;
    logic [AW:0]   fill_cnt;

    logic [DW-1:0] fifo_q[$];
    wr_t           exp_q[$];
    logic          force_empty;
    logic          popped;
    int            n_checks = 0;
    int            n_fail   = 0;

    input_buffer_window_sequencer #(
        .DATA_WIDTH(DW), .SCRATCH_DEPTH(4), .STRIDE(1)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .clear(clear),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_ren(fifo_ren),
        .scratch_wen(scratch_wen), .scratch_waddr(scratch_waddr),
        .scratch_wdata(scratch_wdata), .consume(consume),
        .window_valid(window_valid), .window_base(window_base),
        .fill_cnt(fill_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty = force_empty || (fifo_q.size() == 0);
        fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic load(input logic [DW-1:0] d);
        fifo_q.push_back(d);
        drive_fifo();
    endtask

    task automatic expect_wr(input int a, input logic [DW-1:0] d);
        wr_t e;
        e.addr = AW'(a);
        e.data = d;
        exp_q.push_back(e);
    endtask

    // One clock: sample the pop before the edge, retire the FIFO head after it
    task automatic step();
        @(negedge clk);
        popped = fifo_ren;
        @(posedge clk);
        #1;
        if (popped && fifo_q.size() != 0) void'(fifo_q.pop_front());
        drive_fifo();
    endtask

    task automatic check_status(input string tag, input logic vv, input logic bz,
                                input int base, input int cnt);
        chk({tag, ".window_valid"}, 32'(window_valid), 32'(vv));
        chk({tag, ".busy"},         32'(busy),         32'(bz));
        chk({tag, ".window_base"},  32'(window_base),  32'(base));
        chk({tag, ".fill_cnt"},     32'(fill_cnt),     32'(cnt));
    endtask

    // Monitor: every scratchpad write must match the head of the expected queue
    always @(negedge clk) begin
        if (rstn) begin
            if (scratch_wen) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0d data 0x%0h at %0t",
                             scratch_waddr, scratch_wdata, $time);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(scratch_waddr), 32'(e.addr));
                    chk("wr_data", 32'(scratch_wdata), 32'(e.data));
                end
            end else begin
                chk("idle_wdata_zero", 32'(scratch_wdata), 32'h0);
            end
        end
    end

    initial begin
        rstn = 1'b0; start = 1'b0; clear = 1'b0; consume = 1'b0;
        force_empty = 1'b0; popped = 1'b0;
        drive_fifo();
        #7;
        check_status("reset", 1'b0, 1'b0, 0, 0);
        chk("reset.fifo_ren", 32'(fifo_ren), 32'h0);
        chk("reset.scratch_wen", 32'(scratch_wen), 32'h0);
        chk("reset.waddr", 32'(scratch_waddr), 32'h0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Preloaded fill: four back-to-back writes to addr 0..3
        load(16'h0011); load(16'h0022); load(16'h0033); load(16'h0044);
        expect_wr(0, 16'h0011); expect_wr(1, 16'h0022);
        expect_wr(2, 16'h0033); expect_wr(3, 16'h0044);
        start = 1'b1;
        step();
        start = 1'b0;
        check_status("fill_start", 1'b0, 1'b1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_status($sformatf("fill%0d", i), (i == 3), (i != 3), 0, (i + 1) % 4);
        end
        chk("fill.exp_drained", 32'(exp_q.size()), 32'h0);

        // Five single-word slides wrap the write pointer and window base
        for (int k = 0; k < 5; k++) begin
            load(16'h0055 + 16'(k));
            expect_wr(k % 4, 16'h0055 + 16'(k));
            consume = 1'b1;
            step();
            consume = 1'b0;
            check_status($sformatf("slide%0d.enter", k), 1'b0, 1'b1, (k + 1) % 4, 0);
            step();
            check_status($sformatf("slide%0d.done", k), 1'b1, 1'b0, (k + 1) % 4, 0);
        end
        chk("slide.exp_drained", 32'(exp_q.size()), 32'h0);

        // Abort to IDLE, then fill with the FIFO flickering empty
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_status("clear1", 1'b0, 1'b0, 0, 0);
        load(16'h00a1); load(16'h00a2); load(16'h00a3); load(16'h00a4);
        expect_wr(0, 16'h00a1); expect_wr(1, 16'h00a2);
        expect_wr(2, 16'h00a3); expect_wr(3, 16'h00a4);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            force_empty = (i % 2 == 0);
            drive_fifo();
            step();
            check_status($sformatf("toggle%0d", i), (i == 7), (i != 7), 0, ((i + 1) / 2) % 4);
        end
        force_empty = 1'b0;
        drive_fifo();
        chk("toggle.exp_drained", 32'(exp_q.size()), 32'h0);

        // clear on the cycle of the third pop suppresses that write
        clear = 1'b1;
        step();
        clear = 1'b0;
        load(16'h00b1); load(16'h00b2); load(16'h00b3);
        expect_wr(0, 16'h00b1); expect_wr(1, 16'h00b2);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("pre_clear.fifo_ren", 32'(fifo_ren), 32'h1);
        clear = 1'b1;
        #1;
        chk("clear_pop.fifo_ren", 32'(fifo_ren), 32'h0);
        chk("clear_pop.scratch_wen", 32'(scratch_wen), 32'h0);
        step();
        clear = 1'b0;
        check_status("clear2", 1'b0, 1'b0, 0, 0);
        chk("clear2.fifo_left", 32'(fifo_q.size()), 32'h1);

        // Restart lands at addr 0, proving the write pointer was zeroed
        load(16'h00c2); load(16'h00c3); load(16'h00c4);
        expect_wr(0, 16'h00b3); expect_wr(1, 16'h00c2);
        expect_wr(2, 16'h00c3); expect_wr(3, 16'h00c4);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check_status("refill", 1'b1, 1'b0, 0, 0);

        // Async reset mid-SLIDE: outputs drop with no clock edge
        force_empty = 1'b1;
        drive_fifo();
        consume = 1'b1;
        step();
        consume = 1'b0;
        check_status("slide_hold", 1'b0, 1'b1, 1, 0);
        load(16'h00e1);
        force_empty = 1'b0;
        drive_fifo();
        #1;
        chk("pre_rst.fifo_ren", 32'(fifo_ren), 32'h1);
        rstn = 1'b0;
        #1;
        check_status("async_rst", 1'b0, 1'b0, 0, 0);
        chk("async_rst.fifo_ren", 32'(fifo_ren), 32'h0);
        chk("async_rst.wen", 32'(scratch_wen), 32'h0);
        chk("async_rst.wdata", 32'(scratch_wdata), 32'h0);
        step();
        rstn = 1'b1;
        load(16'h00e2); load(16'h00e3); load(16'h00e4);
        expect_wr(0, 16'h00e1); expect_wr(1, 16'h00e2);
        expect_wr(2, 16'h00e3); expect_wr(3, 16'h00e4);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check_status("post_rst", 1'b1, 1'b0, 0, 0);
        chk("final.exp_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
